// File: rtl/lstm_host_io.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_host_io
//  Description : Host-side companion of the LSTM accelerator. Buffers one
//                input sequence served on addr_x1/data_x1, captures the
//                layer-2 output stream into a result buffer, and sequences
//                an accelerator run (rst_fsm pulse, start, wait for finish).
//                Optional watchdog: define LSTM_HOST_IO_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lstm_host_io #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int IN_DEPTH   = 371,
    parameter int OUT_DEPTH  = 56,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [WIDTH-1:0]      host_wr_data,
    input  logic                  host_go,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic [WIDTH-1:0]      host_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rst_fsm,
    output logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_x1,
    output logic [WIDTH-1:0]      data_x1,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [WIDTH-1:0]      data_h2,
    input  logic                  finish
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int CNT_W  = $clog2(RST_CYCLES) + 1;

    localparam logic [ADDR_WIDTH:0] c_in_depth  = (ADDR_WIDTH + 1)'(IN_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_out_depth = (ADDR_WIDTH + 1)'(OUT_DEPTH);
    localparam logic [CNT_W-1:0]    c_rst_load  = CNT_W'(RST_CYCLES - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_reset = 3'd1;
    localparam logic [2:0] c_st_start = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_ibuf [0:IN_DEPTH-1];
    logic [WIDTH-1:0] r_obuf [0:OUT_DEPTH-1];
    logic [WIDTH-1:0] r_data_x1;
    logic [WIDTH-1:0] r_rd_data;

    logic w_host_open;
    logic w_go;
    logic w_wr_hit;
    logic w_x1_hit;
    logic w_cap_hit;
    logic w_rd_hit;
    logic w_timeout;

    // The host owns the input buffer and may launch only while no run is active
    assign w_host_open = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_go        = host_go && w_host_open;
    assign w_wr_hit    = host_wr_en && w_host_open && ({1'b0, host_wr_addr} < c_in_depth);
    assign w_x1_hit    = ({1'b0, addr_x1} < c_in_depth);
    assign w_cap_hit   = (r_state == c_st_run) && ({1'b0, addr_out} < c_out_depth);
    assign w_rd_hit    = ({1'b0, host_rd_addr} < c_out_depth);

`ifdef LSTM_HOST_IO_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_error;

    // Watchdog counts cycles since start was raised (start cycle = 0);
    // it rests at zero outside START/RUN so every run begins from a clean count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if ((r_state == c_st_start) || (r_state == c_st_run)) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    // Timeout fires so that DONE is entered TIMEOUT cycles after start; finish wins a tie
    assign w_timeout = (r_state == c_st_run) && (r_wdog == c_wd_last) && !finish;

    // Sticky error flag, cleared only by an accepted launch or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_go) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; finish only counts while the accelerator is running
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle,
            c_st_done:  if (host_go) w_state_next = c_st_reset;
            c_st_reset: if (r_cnt == '0) w_state_next = c_st_start;
            c_st_start: w_state_next = c_st_run;
            c_st_run:   if (finish || w_timeout) w_state_next = c_st_done;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // State-decoded control outputs
    always_comb begin
        rst_fsm = 1'b0;
        start   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            c_st_reset: begin rst_fsm = 1'b1; busy = 1'b1; end
            c_st_start: begin start   = 1'b1; busy = 1'b1; end
            c_st_run:   busy = 1'b1;
            c_st_done:  done = 1'b1;
            default:    ;
        endcase
    end

    // rst_fsm hold counter: loaded on launch, walks down to zero in RESET
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_go) begin
            r_cnt <= c_rst_load;
        end else if ((r_state == c_st_reset) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Input buffer write port (host side); contents deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_ibuf[host_wr_addr[IN_AW-1:0]] <= host_wr_data;
        end
    end

    // Input buffer read port (accelerator side), 1-cycle latency, zero when out of range
    always_ff @(posedge clk) begin
        if (rst || !w_x1_hit) begin
            r_data_x1 <= '0;
        end else begin
            r_data_x1 <= r_ibuf[addr_x1[IN_AW-1:0]];
        end
    end

    // Output buffer capture of the layer-2 stream during RUN; last write wins
    always_ff @(posedge clk) begin
        if (w_cap_hit) begin
            r_obuf[addr_out[OUT_AW-1:0]] <= data_h2;
        end
    end

    // Host read of the output buffer; a same-cycle capture is seen one cycle later
    always_ff @(posedge clk) begin
        if (rst || !w_rd_hit) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_obuf[host_rd_addr[OUT_AW-1:0]];
        end
    end

    assign data_x1      = r_data_x1;
    assign host_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_lstm_host_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lstm_host_io
//  Description : Randomised self-checking bench for lstm_host_io against a
//                behavioural buffer/sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_host_io;

    localparam int WIDTH      = 32;
    localparam int AW         = 12;
    localparam int IN_DEPTH   = 371;
    localparam int OUT_DEPTH  = 56;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [31:0]   host_wr_data;
    logic          host_go;
    logic [AW-1:0] host_rd_addr;
    logic [31:0]   host_rd_data;
    logic          busy, done, error, rst_fsm, start;
    logic [AW-1:0] addr_x1;
    logic [31:0]   data_x1;
    logic [AW-1:0] addr_out;
    logic [31:0]   data_h2;
    logic          finish;

    lstm_host_io #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_go(host_go), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
        .busy(busy), .done(done), .error(error), .rst_fsm(rst_fsm), .start(start),
        .addr_x1(addr_x1), .data_x1(data_x1), .addr_out(addr_out), .data_h2(data_h2),
        .finish(finish)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays plus "has been written" flags
    logic [31:0] ibuf_m [IN_DEPTH];
    bit          ibuf_ok [IN_DEPTH];
    logic [31:0] obuf_m [OUT_DEPTH];
    bit          obuf_ok [OUT_DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        host_wr_en = 1'b1; host_wr_addr = AW'(a); host_wr_data = d;
        tick();
        host_wr_en = 1'b0;
        if (a < IN_DEPTH) begin ibuf_m[a] = d; ibuf_ok[a] = 1'b1; end
    endtask

    task automatic read_x1(input int a);
        addr_x1 = AW'(a);
        tick();
        if (a >= IN_DEPTH)   check_value("x1_out_of_range", data_x1, 0);
        else if (ibuf_ok[a]) check_value("x1_read", data_x1, ibuf_m[a]);
    endtask

    task automatic read_out(input int a);
        host_rd_addr = AW'(a);
        tick();
        if (a >= OUT_DEPTH)  check_value("obuf_out_of_range", host_rd_data, 0);
        else if (obuf_ok[a]) check_value("obuf_read", host_rd_data, obuf_m[a]);
    endtask

    // Launch from IDLE/DONE and follow the control sequence up to RUN
    task automatic launch(input bit noise, input bit co_wr, input int co_a, input logic [31:0] co_d);
        host_go = 1'b1;
        if (co_wr) begin
            host_wr_en = 1'b1; host_wr_addr = AW'(co_a); host_wr_data = co_d;
            ibuf_m[co_a] = co_d; ibuf_ok[co_a] = 1'b1;
        end
        tick();
        host_go = 1'b0; host_wr_en = 1'b0;
        addr_x1 = AW'(co_a);
        for (int i = 0; i < RST_CYCLES + 3; i++) begin
            check_value("seq_rst_fsm", rst_fsm, (i < RST_CYCLES) ? 1 : 0);
            check_value("seq_start", start, (i == RST_CYCLES) ? 1 : 0);
            check_value("seq_busy", busy, 1);
            check_value("seq_done", done, 0);
            check_value("seq_error", error, 0);
            if (co_wr && i == 1) check_value("go_with_write", data_x1, co_d);
            // stray finish/go before RUN must not disturb the sequence
            finish  = noise && (i <= RST_CYCLES);
            host_go = noise;
            tick();
        end
        finish = 1'b0; host_go = 1'b0;
    endtask

    // One RUN cycle: capture one output word while the host reads
    task automatic capture(input int a, input logic [31:0] d, input int rd, input bit noise);
        logic [31:0] old_v;
        bit          old_ok;
        old_ok = (rd < OUT_DEPTH) && obuf_ok[rd];
        old_v  = (rd < OUT_DEPTH) ? obuf_m[rd] : 32'h0;
        addr_out = AW'(a); data_h2 = d; host_rd_addr = AW'(rd);
        if (noise) begin
            host_go = 1'b1; host_wr_en = 1'b1; host_wr_addr = '0; host_wr_data = ~ibuf_m[0];
        end
        tick();
        host_go = 1'b0; host_wr_en = 1'b0;
        if (rd >= OUT_DEPTH) check_value("run_rd_oor", host_rd_data, 0);
        else if (old_ok)     check_value("run_rd_old", host_rd_data, old_v);
        check_value("run_rst_fsm", rst_fsm, 0);
        check_value("run_start", start, 0);
        check_value("run_busy", busy, 1);
        if (a < OUT_DEPTH) begin obuf_m[a] = d; obuf_ok[a] = 1'b1; end
    endtask

    task automatic finish_run();
        addr_out = '1; finish = 1'b1;
        tick();
        finish = 1'b0;
        check_value("end_done", done, 1);
        check_value("end_busy", busy, 0);
        check_value("end_error", error, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_busy"}, busy, 0);
        check_value({tag, "_done"}, done, 0);
        check_value({tag, "_error"}, error, 0);
        check_value({tag, "_rst_fsm"}, rst_fsm, 0);
        check_value({tag, "_start"}, start, 0);
        check_value({tag, "_data_x1"}, data_x1, 0);
        check_value({tag, "_rd_data"}, host_rd_data, 0);
    endtask

    initial begin
        int t;
        int low;
        rst = 1'b1; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        host_go = 1'b0; host_rd_addr = '0; addr_x1 = '0; addr_out = '1;
        data_h2 = '0; finish = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Input buffer: corner words, random fill, dropped out-of-range writes
        host_write(0, 32'h0100_0000);
        host_write(370, 32'hFF00_0000);
        for (int i = 0; i < 30; i++) host_write($urandom_range(1, 369), $urandom);
        host_write(512, 32'hDEAD_BEEF);
        host_write(882, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) host_write($urandom_range(IN_DEPTH, 4095), $urandom);
        read_x1(0);
        check_value("x1_word0", data_x1, 32'h0100_0000);
        read_x1(370);
        check_value("x1_word370", data_x1, 32'hFF00_0000);
        read_x1(371);
        for (int i = 0; i < 20; i++) read_x1($urandom_range(0, 511));

        // Run 1: launch with a same-cycle write, ramp capture with RUN-time noise
        launch(1'b0, 1'b1, 5, $urandom);
        for (int a = 0; a < OUT_DEPTH; a++)
            capture(a, 32'h100 + 32'(a), $urandom_range(0, 63), (a % 9) == 4);
        for (int i = 0; i < 4; i++) capture($urandom_range(OUT_DEPTH, 127), $urandom, 0, 1'b0);
        finish_run();
        read_out(55);
        check_value("obuf55", host_rd_data, 32'h137);
        read_out(60);
        for (int a = 0; a < OUT_DEPTH; a++) read_out(a);
        read_x1(0);

        // Run 2: relaunch from DONE with stray go/finish; read-while-capture same address
        launch(1'b1, 1'b0, 370, 32'h0);
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 59);
            capture(t, $urandom, t, 1'b0);
        end
        finish_run();
        for (int i = 0; i < 10; i++) read_out($urandom_range(0, 63));

        // Run 3: reset mid-run, then a clean run
        launch(1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 5; i++) capture($urandom_range(0, 55), $urandom, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrun_rst");
        launch(1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 5; i++) capture($urandom_range(0, 55), $urandom, 1, 1'b0);
        finish_run();
        for (int i = 0; i < 8; i++) read_out($urandom_range(0, 55));

        // Run 4: no finish at all
        launch(1'b0, 1'b0, 0, 32'h0);
`ifdef LSTM_HOST_IO_TIMEOUT_EN
        t = RST_CYCLES + 3 - RST_CYCLES;
        while (done !== 1'b1 && t < TIMEOUT + 50) begin tick(); t++; end
        check_value("wd_cycles_after_start", t, TIMEOUT);
        check_value("wd_error", error, 1);
        check_value("wd_busy", busy, 0);
        launch(1'b0, 1'b0, 0, 32'h0);
`else
        low = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) low++;
            tick();
        end
        check_value("no_wd_busy_held", low, 0);
        check_value("no_wd_error", error, 0);
`endif
        rst = 1'b1;
        tick();
        check_all_zero("final_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end, expected end of stimulus");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/lstm_host_io.md
Name: lstm_host_io

Overview:
- Host-side counterpart of the LSTM accelerator top level on the Zybo build.
- Buffers one input sequence and serves it to the accelerator on demand: the accelerator drives addr_x1, this block returns data_x1.
- Captures the layer-2 output stream (addr_out, data_h2) into a result buffer.
- Sequences the accelerator run (rst_fsm pulse, start, wait for finish) and exposes a simple register-style host port.

Parameters:
- WIDTH, 32, data word width (Q8.24 fixed point, passed through untouched).
- ADDR_WIDTH, 12, width of all address ports.
- IN_DEPTH, 371, input buffer words (TIMESTEP 7 x LAYR1_INPUT 53).
- OUT_DEPTH, 56, output buffer words (TIMESTEP 7 x LAYR2_CELL 8).
- RST_CYCLES, 2, cycles rst_fsm is held high before start.
- TIMEOUT, 65535, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- host_wr_en  in  1  write strobe into the input buffer.
- host_wr_addr  in  ADDR_WIDTH  input buffer write address.
- host_wr_data  in  WIDTH  input buffer write data.
- host_go  in  1  single-cycle request to launch a run.
- host_rd_addr  in  ADDR_WIDTH  output buffer read address.
- host_rd_data  out  WIDTH  output buffer read data, 1-cycle registered.
- busy  out  1  high from host_go acceptance until DONE.
- done  out  1  sticky completion flag; cleared by the next accepted host_go.
- error  out  1  sticky timeout flag.
- rst_fsm  out  1  accelerator FSM reset.
- start  out  1  accelerator start.
- addr_x1  in  ADDR_WIDTH  accelerator input read address.
- data_x1  out  WIDTH  input word, registered, valid 1 cycle after addr_x1.
- addr_out  in  ADDR_WIDTH  accelerator output address.
- data_h2  in  WIDTH  accelerator output word.
- finish  in  1  accelerator completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Buffer contents are not reset.
- Input buffer: dual-port, IN_DEPTH x WIDTH.
  - Host write takes effect at the clock edge when host_wr_en=1 and host_wr_addr<IN_DEPTH. Out-of-range writes are dropped.
  - Host writes are accepted in IDLE and DONE only; they are ignored while busy.
  - Read side: data_x1 <= buf[addr_x1] every cycle in every state (1-cycle latency). An out-of-range addr_x1 returns 0.
- Output buffer: OUT_DEPTH x WIDTH.
  - In RUN, every cycle with addr_out<OUT_DEPTH writes data_h2 at addr_out; the last write wins.
  - host_rd_data <= obuf[host_rd_addr] every cycle (1-cycle latency); out-of-range returns 0.
- FSM states:
  - IDLE: host_go -> RESET. The transition clears done and error and loads the cycle counter with RST_CYCLES-1.
  - RESET: rst_fsm=1; the counter decrements; at 0 -> START.
  - START: start=1 for exactly one cycle -> RUN. The watchdog counter is cleared.
  - RUN: start=0, rst_fsm=0; finish=1 -> DONE.
  - DONE: done=1, busy=0; host_go -> RESET, same as from IDLE.
- busy=1 in RESET, START and RUN.
- host_go is ignored while busy.
- A finish seen in RESET or START is ignored; only a finish in RUN ends the run.
- Simultaneous events:
  - host_go with host_wr_en in IDLE: both take effect; the write lands before the first accelerator read.
  - Output capture and host read of the same address in the same cycle: host sees the old value.
- rst asserted mid-run: FSM returns to IDLE next edge, rst_fsm=0, start=0, done=0, error=0. The accelerator is left free-running until the next run pulses rst_fsm.

Optional Feature:
- Macro: LSTM_HOST_IO_TIMEOUT_EN.
- Defined: a watchdog counter increments in RUN. Reaching TIMEOUT without finish -> DONE with error=1 and done=1. error clears on the next accepted host_go or on rst.
- Undefined: no watchdog; RUN waits for finish indefinitely; error is tied to 0.

Test Plan:
- Reset, then write buf[0]=0x01000000 and buf[370]=0xFF000000; drive addr_x1=0, then 370, then 371 -> data_x1 is 0x01000000, then 0xFF000000, then 0, each 1 cycle after its address.
- Pulse host_go in IDLE -> rst_fsm high exactly 2 cycles, then start high exactly 1 cycle, busy high from the cycle after host_go.
- In RUN, drive addr_out=0..55 with data_h2=addr+0x100, then pulse finish -> done=1 and busy=0 next cycle; host_rd_addr=55 returns 0x137; a second host_go clears done.
- host_go and host_wr_en pulsed during RUN -> both ignored: buffer unchanged, no rst_fsm or start pulse.
- rst asserted during RUN -> IDLE next edge, all outputs 0; a later host_go runs a normal sequence.
- With LSTM_HOST_IO_TIMEOUT_EN defined and TIMEOUT=100, no finish -> DONE with error=1 exactly 100 cycles after start; without the macro, busy stays high.
